// File: rtl/peak_bin_tracker_if.sv
// Bin-stream interface for peak_bin_tracker. The upstream bin-magnitude stage
// drives the master side and the tracker sits on the slave side.
interface peak_bin_tracker_if #(
  parameter int DATA_W = 20,
  parameter int IDX_W  = 2
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              frame_restart;
  logic [DATA_W-1:0] threshold;
  logic              hold_mode;
  logic              out_valid;
  logic [IDX_W-1:0]  out_index;
  logic [DATA_W-1:0] out_value;
  logic              out_above;
  logic              busy;

  modport master (
    output in_valid, in_data, frame_restart, threshold, hold_mode,
    input  out_valid, out_index, out_value, out_above, busy
  );

  modport slave (
    input  in_valid, in_data, frame_restart, threshold, hold_mode,
    output out_valid, out_index, out_value, out_above, busy
  );
endinterface

// File: rtl/peak_bin_tracker.sv
// Streaming argmax over frames of NUM_BINS unsigned bin magnitudes.
// Stage p0 tracks the running winner of the current frame. Stage p1 holds
// the published result of the last completed frame, one clock after its
// final bin. Ties keep the earliest bin. In hold mode a weak frame leaves
// the published index unchanged.
module peak_bin_tracker #(
  parameter int DATA_W   = 20,
  parameter int NUM_BINS = 4,
  parameter int IDX_W    = $clog2(NUM_BINS)
) (
  input logic               clk,
  input logic               rst_n,
  peak_bin_tracker_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);

  // Strict unsigned compare: a later bin equal to the incumbent never wins.
  function automatic logic beats(input logic [DATA_W-1:0] cand,
                                 input logic [DATA_W-1:0] incumbent);
    return cand > incumbent;
  endfunction

  function automatic logic meets(input logic [DATA_W-1:0] val,
                                 input logic [DATA_W-1:0] thr);
    return val >= thr;
  endfunction

  logic [IDX_W-1:0]  bin_cnt_p0;
  logic [DATA_W-1:0] best_val_p0;
  logic [IDX_W-1:0]  best_idx_p0;
  logic              busy_p0;

  logic              vld_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [DATA_W-1:0] val_p1;
  logic              above_p1;

  logic              accept;
  logic              first_bin;
  logic              last_bin;
  logic              take_new;
  logic              win_above;
  logic [DATA_W-1:0] win_val;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  bin_cnt_nxt;

  // Winner including the bin presented this cycle, and the next bin count.
  always_comb begin
    accept    = bus.in_valid && !bus.frame_restart;
    first_bin = (bin_cnt_p0 == '0);
    last_bin  = (bin_cnt_p0 == LAST_BIN);
    // On the first bin bin_cnt is 0, so win_idx is 0 without a separate path.
    take_new  = first_bin || beats(bus.in_data, best_val_p0);
    win_val   = take_new ? bus.in_data : best_val_p0;
    win_idx   = take_new ? bin_cnt_p0 : best_idx_p0;
    win_above = meets(win_val, bus.threshold);

    bin_cnt_nxt = bin_cnt_p0;
    if (bus.frame_restart) begin
      bin_cnt_nxt = '0;
    end else if (bus.in_valid) begin
      bin_cnt_nxt = last_bin ? '0 : bin_cnt_p0 + IDX_W'(1);
    end
  end

  // ---- stage p0: running frame maximum ----
  // Update bin position, busy flag and the running winner on each accepted bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_p0  <= '0;
      best_val_p0 <= '0;
      best_idx_p0 <= '0;
      busy_p0     <= 1'b0;
    end else begin
      bin_cnt_p0 <= bin_cnt_nxt;
      busy_p0    <= (bin_cnt_nxt != '0);
      if (accept) begin
        best_val_p0 <= win_val;
        best_idx_p0 <= win_idx;
      end
    end
  end

  // ---- stage p1: published frame result ----
  // Publish on the last accepted bin; a restart on that cycle suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      val_p1   <= '0;
      above_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept && last_bin;
      if (accept && last_bin) begin
        val_p1   <= win_val;
        above_p1 <= win_above;
        if (!(bus.hold_mode && !win_above)) begin
          idx_p1 <= win_idx;
        end
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_index = idx_p1;
  assign bus.out_value = val_p1;
  assign bus.out_above = above_p1;
  assign bus.busy      = busy_p0;

endmodule

// File: tb/tb_peak_bin_tracker.sv
// Bench for peak_bin_tracker: directed frames on a 4-bin/20-bit instance and
// a randomized stream on a 16-bin/8-bit instance checked against a
// frame-level argmax model.
module tb_peak_bin_tracker;
  localparam int AW = 20;
  localparam int AN = 4;
  localparam int AI = $clog2(AN);
  localparam int BW = 8;
  localparam int BN = 16;
  localparam int BI = $clog2(BN);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  peak_bin_tracker_if #(.DATA_W(AW), .IDX_W(AI)) ia ();
  peak_bin_tracker_if #(.DATA_W(BW), .IDX_W(BI)) ib ();

  peak_bin_tracker #(.DATA_W(AW), .NUM_BINS(AN)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  peak_bin_tracker #(.DATA_W(BW), .NUM_BINS(BN)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out_a(input string tag, input logic v, input int idx,
                           input logic [AW-1:0] val, input logic ab);
    chk({tag, ".valid"}, 32'(ia.out_valid), 32'(v));
    chk({tag, ".index"}, 32'(ia.out_index), 32'(idx));
    chk({tag, ".value"}, 32'(ia.out_value), 32'(val));
    chk({tag, ".above"}, 32'(ia.out_above), 32'(ab));
  endtask

  // One clock on instance A: drive at the falling edge, sample at the next one.
  task automatic step_a(input string tag, input logic v, input logic [AW-1:0] d,
                        input logic rs, input logic exp_vld, input logic exp_busy);
    ia.in_valid = v;
    ia.in_data = d;
    ia.frame_restart = rs;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld"}, 32'(ia.out_valid), 32'(exp_vld));
    chk({tag, ".busy"}, 32'(ia.busy), 32'(exp_busy));
  endtask

  task automatic frame_a(input string tag, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                         input logic [AW-1:0] b2, input logic [AW-1:0] b3);
    step_a({tag, ".b0"}, 1'b1, b0, 1'b0, 1'b0, 1'b1);
    step_a({tag, ".b1"}, 1'b1, b1, 1'b0, 1'b0, 1'b1);
    step_a({tag, ".b2"}, 1'b1, b2, 1'b0, 1'b0, 1'b1);
    step_a({tag, ".b3"}, 1'b1, b3, 1'b0, 1'b1, 1'b0);
  endtask

  // Reference model state for instance B.
  logic [BW-1:0] q[$];
  logic [BI-1:0] e_idx = '0;
  logic [BW-1:0] e_val = '0;
  logic          e_above = 1'b0;
  logic          e_vld;
  logic [BW-1:0] mx;
  int            mi;
  logic          rv, rrs, rhm;
  logic [BW-1:0] rd, rthr;

  initial begin
    ia.in_valid = 1'b0; ia.in_data = '0; ia.frame_restart = 1'b0;
    ia.threshold = '0; ia.hold_mode = 1'b0;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.frame_restart = 1'b0;
    ib.threshold = '0; ib.hold_mode = 1'b0;

    repeat (2) @(negedge clk);
    chk_out_a("rst", 1'b0, 0, '0, 1'b0);
    chk("rst.busy", 32'(ia.busy), 32'd0);
    chk("rstb.index", 32'(ib.out_index), 32'd0);
    chk("rstb.value", 32'(ib.out_value), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, then the pulse must drop.
    frame_a("basic", 20'd5, 20'd9, 20'd3, 20'd7);
    chk_out_a("basic", 1'b1, 1, 20'd9, 1'b1);
    step_a("basic.after", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_out_a("basic.hold", 1'b0, 1, 20'd9, 1'b1);

    // Ties go to the lowest index.
    frame_a("tie", 20'd8, 20'd8, 20'd2, 20'd8);
    chk_out_a("tie", 1'b1, 0, 20'd8, 1'b1);
    frame_a("zero", 20'd0, 20'd0, 20'd0, 20'd0);
    chk_out_a("zero", 1'b1, 0, 20'd0, 1'b1);

    // Hold mode on a weak frame.
    ia.threshold = 20'd10;
    frame_a("hA", 20'd1, 20'd2, 20'd30, 20'd4);
    chk_out_a("hA", 1'b1, 2, 20'd30, 1'b1);
    ia.hold_mode = 1'b1;
    frame_a("hB1", 20'd6, 20'd1, 20'd1, 20'd1);
    chk_out_a("hB1", 1'b1, 2, 20'd6, 1'b0);
    ia.hold_mode = 1'b0;
    frame_a("hB0", 20'd6, 20'd1, 20'd1, 20'd1);
    chk_out_a("hB0", 1'b1, 0, 20'd6, 1'b0);

    // Gaps mid-frame and a restart.
    ia.threshold = '0;
    step_a("gap.b0", 1'b1, 20'd4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step_a("gap.idle", 1'b0, 20'd99, 1'b0, 1'b0, 1'b1);
    step_a("gap.b1", 1'b1, 20'd20, 1'b0, 1'b0, 1'b1);
    step_a("gap.rst", 1'b1, 20'd77, 1'b1, 1'b0, 1'b0);
    frame_a("gap.fr", 20'd1, 20'd2, 20'd3, 20'hFFFFF);
    chk_out_a("gap", 1'b1, 3, 20'hFFFFF, 1'b1);
    step_a("gap.after", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Restart on the last-bin cycle publishes nothing.
    step_a("lrs.b0", 1'b1, 20'd11, 1'b0, 1'b0, 1'b1);
    step_a("lrs.b1", 1'b1, 20'd12, 1'b0, 1'b0, 1'b1);
    step_a("lrs.b2", 1'b1, 20'd13, 1'b0, 1'b0, 1'b1);
    step_a("lrs.b3", 1'b1, 20'd50, 1'b1, 1'b0, 1'b0);
    chk_out_a("lrs", 1'b0, 3, 20'hFFFFF, 1'b1);

    // Back-to-back frames, no idle cycles.
    frame_a("bb1", 20'd1, 20'd7, 20'd7, 20'd2);
    chk_out_a("bb1", 1'b1, 1, 20'd7, 1'b1);
    frame_a("bb2", 20'd9, 20'd0, 20'd0, 20'd10);
    chk_out_a("bb2", 1'b1, 3, 20'd10, 1'b1);
    frame_a("bb3", 20'd0, 20'd3, 20'd0, 20'd0);
    chk_out_a("bb3", 1'b1, 1, 20'd3, 1'b1);

    // Asynchronous reset mid-frame.
    step_a("ar.b0", 1'b1, 20'd40, 1'b0, 1'b0, 1'b1);
    step_a("ar.b1", 1'b1, 20'd41, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out_a("ar", 1'b0, 0, '0, 1'b0);
    chk("ar.busy", 32'(ia.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ia.threshold = 20'd3;
    frame_a("ar.fr", 20'd2, 20'd5, 20'd5, 20'd1);
    chk_out_a("ar.fr", 1'b1, 1, 20'd5, 1'b1);
    step_a("ar.after", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized stream on the 16-bin instance.
    for (int c = 0; c < 700; c++) begin
      rv   = ($urandom_range(0, 9) != 0);
      rrs  = ($urandom_range(0, 39) == 0);
      rhm  = 1'($urandom_range(0, 1));
      rthr = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       rd = 8'($urandom_range(0, 3));
        1:       rd = 8'hFF;
        default: rd = 8'($urandom_range(0, 255));
      endcase

      e_vld = 1'b0;
      if (rrs) begin
        q.delete();
      end else if (rv) begin
        q.push_back(rd);
        if (q.size() == BN) begin
          mx = q[0];
          mi = 0;
          for (int i = 1; i < BN; i++) begin
            if (q[i] > mx) begin
              mx = q[i];
              mi = i;
            end
          end
          e_val = mx;
          e_above = (mx >= rthr);
          if (!(rhm && !e_above)) e_idx = BI'(mi);
          e_vld = 1'b1;
          q.delete();
        end
      end

      ib.in_valid = rv;
      ib.in_data = rd;
      ib.frame_restart = rrs;
      ib.threshold = rthr;
      ib.hold_mode = rhm;
      @(posedge clk);
      @(negedge clk);
      chk("rnd.vld", 32'(ib.out_valid), 32'(e_vld));
      chk("rnd.busy", 32'(ib.busy), 32'(q.size() != 0));
      chk("rnd.index", 32'(ib.out_index), 32'(e_idx));
      chk("rnd.value", 32'(ib.out_value), 32'(e_val));
      chk("rnd.above", 32'(ib.out_above), 32'(e_above));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
